// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner
//  Description : Scans a 4x3 active-low key matrix, debounces whole-matrix
//                snapshots and emits single-cycle key events for the
//                microwave controller.
//
//                Matrix layout (row,col), snapshot bit = 3*row + col:
//                    r0 = 1 2 3
//                    r1 = 4 5 6
//                    r2 = 7 8 9
//                    r3 = * 0 #
//
//  Ports       : clk       in   system clock, rising edge
//                clearn    in   asynchronous active-low reset
//                col_n     in   [2:0] column sense, active low
//                row_n     out  [3:0] row drive, active low, one-cold
//                keypad    out  [9:0] one-hot digit event, 1 clk wide
//                startn    out  '#' event, low for 1 clk
//                clr_keyn  out  '*' event, low for 1 clk
//
//  Parameters  : SCAN_DIV  clk cycles each row is driven (>= 2)
//                DEBOUNCE  extra identical frames to accept a state (>= 1)
//
//  Revision    : 1.0  initial release
// ============================================================================
module keypad_scanner #(
    parameter int SCAN_DIV = 10,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic [2:0] col_n,
    output logic [3:0] row_n,
    output logic [9:0] keypad,
    output logic       startn,
    output logic       clr_keyn
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] C_CNT_ARM  = CNT_W'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESSED = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    // Scan
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_row;
    logic [3:0]       r_row_n;
    logic [11:0]      r_snap;
    logic [1:0]       w_row_nxt;
    logic             w_sample;
    logic             w_frame_end;
    logic [11:0]      w_snap_full;

    // Debounce
    logic [11:0]      r_prev_snap;
    logic [CNT_W-1:0] r_cnt;
    logic [11:0]      r_accepted;
    logic             r_acc_valid;
    logic             w_same;

    // Event FSM
    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_acc_zero;
    logic             w_acc_single;
    logic [9:0]       r_keypad;
    logic             r_startn;
    logic             r_clr_keyn;
    logic [9:0]       w_keypad_nxt;
    logic             w_startn_nxt;
    logic             w_clr_keyn_nxt;

    // ------------------------------------------------------------------------
    // Row scanning
    // ------------------------------------------------------------------------
    assign w_sample    = (r_div == C_DIV_LAST);
    assign w_frame_end = w_sample && (r_row == 2'd3);
    assign w_row_nxt   = r_row + 2'd1;

    // Snapshot including the row being sampled this cycle, so the frame-end
    // comparison sees the complete matrix without an extra cycle of delay.
    always_comb begin
        w_snap_full = r_snap;
        case (r_row)
            2'd0:    w_snap_full[2:0]  = ~col_n;
            2'd1:    w_snap_full[5:3]  = ~col_n;
            2'd2:    w_snap_full[8:6]  = ~col_n;
            default: w_snap_full[11:9] = ~col_n;
        endcase
    end

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            r_div   <= '0;
            r_row   <= 2'd0;
            r_row_n <= 4'b1110;
            r_snap  <= '0;
        end else if (w_sample) begin
            r_div   <= '0;
            r_row   <= w_row_nxt;
            r_row_n <= ~(4'b0001 << w_row_nxt);
            r_snap  <= w_snap_full;
        end else begin
            r_div   <= r_div + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Frame debounce: the count saturates at DEBOUNCE, so a held state is
    // accepted exactly once, on the transition into saturation.
    // ------------------------------------------------------------------------
    assign w_same = (w_snap_full == r_prev_snap);

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            r_prev_snap <= '0;
            r_cnt       <= '0;
            r_accepted  <= '0;
            r_acc_valid <= 1'b0;
        end else begin
            r_acc_valid <= 1'b0;
            if (w_frame_end) begin
                r_prev_snap <= w_snap_full;
                if (w_same) begin
                    if (r_cnt != C_CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (r_cnt == C_CNT_ARM) begin
                        r_accepted  <= w_snap_full;
                        r_acc_valid <= 1'b1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Event FSM
    // ------------------------------------------------------------------------
    assign w_acc_zero   = (r_accepted == 12'd0);
    assign w_acc_single = !w_acc_zero &&
                          ((r_accepted & (r_accepted - 12'd1)) == 12'd0);

    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            r_state    <= S_IDLE;
            r_keypad   <= '0;
            r_startn   <= 1'b1;
            r_clr_keyn <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_keypad   <= w_keypad_nxt;
            r_startn   <= w_startn_nxt;
            r_clr_keyn <= w_clr_keyn_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_keypad_nxt   = '0;
        w_startn_nxt   = 1'b1;
        w_clr_keyn_nxt = 1'b1;
        if (r_acc_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc_single) begin
                        w_state_nxt = S_PRESSED;
                        // Single set bit: map matrix position to its event.
                        case (r_accepted)
                            12'h001: w_keypad_nxt[1] = 1'b1;
                            12'h002: w_keypad_nxt[2] = 1'b1;
                            12'h004: w_keypad_nxt[3] = 1'b1;
                            12'h008: w_keypad_nxt[4] = 1'b1;
                            12'h010: w_keypad_nxt[5] = 1'b1;
                            12'h020: w_keypad_nxt[6] = 1'b1;
                            12'h040: w_keypad_nxt[7] = 1'b1;
                            12'h080: w_keypad_nxt[8] = 1'b1;
                            12'h100: w_keypad_nxt[9] = 1'b1;
                            12'h200: w_clr_keyn_nxt  = 1'b0;
                            12'h400: w_keypad_nxt[0] = 1'b1;
                            12'h800: w_startn_nxt    = 1'b0;
                            default: ;
                        endcase
                    end else if (!w_acc_zero) begin
                        w_state_nxt = S_LOCKED;
                    end
                end
                S_PRESSED: begin
                    // Any accepted change while held is a chord or a slide;
                    // it never produces a second event.
                    w_state_nxt = w_acc_zero ? S_IDLE : S_LOCKED;
                end
                S_LOCKED: begin
                    if (w_acc_zero) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign row_n    = r_row_n;
    assign keypad   = r_keypad;
    assign startn   = r_startn;
    assign clr_keyn = r_clr_keyn;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scanner
//  Description : Self-checking bench for keypad_scanner (SCAN_DIV=4,
//                DEBOUNCE=2, 16-clk frame). Stimulus pushes expected events
//                with an allowed cycle window; a monitor pops and compares
//                every event the DUT presents.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_keypad_scanner;

    localparam int FRAME = 16;

    logic       clk;
    logic       clearn;
    logic [2:0] col_n;
    logic [3:0] row_n;
    logic [9:0] keypad;
    logic       startn;
    logic       clr_keyn;

    // Held keys, bit = 3*row + col
    logic [11:0] held;

    int unsigned t;
    int          total;
    int          bad;

    typedef struct {
        logic [11:0] evt;
        int unsigned tmin;
        int unsigned tmax;
    } exp_t;

    exp_t q[$];

    keypad_scanner #(
        .SCAN_DIV (4),
        .DEBOUNCE (2)
    ) dut (
        .clk      (clk),
        .clearn   (clearn),
        .col_n    (col_n),
        .row_n    (row_n),
        .keypad   (keypad),
        .startn   (startn),
        .clr_keyn (clr_keyn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles since reset release; 0 while in reset.
    always @(posedge clk) begin
        if (!clearn) t <= 0;
        else         t <= t + 1;
    end

    // Matrix model: a column reads low when a held key sits on a driven row.
    always_comb begin
        col_n = 3'b111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (held[3*r+c] && !row_n[r]) col_n[c] = 1'b0;
            end
        end
    end

    // Event monitor: event word = {clr, start, keypad}
    logic [11:0] m_ev;
    exp_t        m_e;
    always @(negedge clk) begin
        m_ev = {~clr_keyn, ~startn, keypad};
        if (m_ev != 12'd0) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event got=%h required=none t=%0d", m_ev, t);
            end else begin
                m_e = q.pop_front();
                if (m_ev !== m_e.evt || t < m_e.tmin || t > m_e.tmax) begin
                    bad++;
                    $display("FAIL event got=%h at t=%0d required=%h in t=[%0d,%0d]",
                             m_ev, t, m_e.evt, m_e.tmin, m_e.tmax);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic expect_evt(input logic [11:0] evt, input int unsigned at);
        exp_t e;
        e.evt  = evt;
        e.tmin = at - 1;
        e.tmax = at + 1;
        q.push_back(e);
    endtask

    task automatic wait_t(input int unsigned target);
        while (t < target) @(negedge clk);
    endtask

    task automatic align();
        while ((t % FRAME) != 0) @(negedge clk);
    endtask

    task automatic idle_frames(input int n);
        held = 12'd0;
        repeat (n * FRAME) @(negedge clk);
        align();
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_row_n"},    {28'd0, row_n},    32'h0000_000E);
        chk({name, "_keypad"},   {22'd0, keypad},   32'd0);
        chk({name, "_startn"},   {31'd0, startn},   32'd1);
        chk({name, "_clr_keyn"}, {31'd0, clr_keyn}, 32'd1);
    endtask

    int unsigned tb0;

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0d", t);
        $fatal(1, "watchdog");
    end

    initial begin
        total  = 0;
        bad    = 0;
        held   = 12'd0;
        clearn = 1'b0;
        repeat (3) @(negedge clk);

        // 1: reset state and row scan sequence
        chk_idle_outputs("reset");
        clearn = 1'b1;
        chk("row_t0",  {28'd0, row_n}, 32'hE);
        wait_t(3);  chk("row_t3",  {28'd0, row_n}, 32'hE);
        wait_t(4);  chk("row_t4",  {28'd0, row_n}, 32'hD);
        wait_t(8);  chk("row_t8",  {28'd0, row_n}, 32'hB);
        wait_t(12); chk("row_t12", {28'd0, row_n}, 32'h7);
        wait_t(16); chk("row_t16", {28'd0, row_n}, 32'hE);
        idle_frames(4);

        // 2: hold '5' 20 frames -> one pulse on keypad[5]
        tb0 = t;
        held = 12'h010;
        expect_evt(12'h020, tb0 + 49);
        wait_t(tb0 + 20 * FRAME);
        idle_frames(4);
        chk("t2_drain", q.size(), 0);

        // 3: '2' toggled each frame for 5 frames, then steady
        tb0 = t;
        expect_evt(12'h004, tb0 + 113);
        for (int k = 0; k < 5; k++) begin
            held = (k % 2 == 0) ? 12'h002 : 12'h000;
            wait_t(tb0 + FRAME * (k + 1));
        end
        wait_t(tb0 + 10 * FRAME);
        idle_frames(4);
        chk("t3_drain", q.size(), 0);

        // 4: '#' then '*'
        tb0 = t;
        held = 12'h800;
        expect_evt(12'h400, tb0 + 49);
        wait_t(tb0 + 4 * FRAME);
        idle_frames(4);
        tb0 = t;
        held = 12'h200;
        expect_evt(12'h800, tb0 + 49);
        wait_t(tb0 + 4 * FRAME);
        idle_frames(4);
        chk("t4_drain", q.size(), 0);

        // 5: chord '2'+'5' locks out, release '2' still locked, then '4'
        tb0 = t;
        held = 12'h012;
        wait_t(tb0 + 4 * FRAME);
        held = 12'h010;
        wait_t(tb0 + 8 * FRAME);
        idle_frames(4);
        tb0 = t;
        held = 12'h008;
        expect_evt(12'h010, tb0 + 49);
        wait_t(tb0 + 4 * FRAME);
        idle_frames(4);
        chk("t5_drain", q.size(), 0);

        // 6: reset during 2nd stable frame of '9'
        tb0 = t;
        held = 12'h100;
        wait_t(tb0 + 24);
        clearn = 1'b0;
        #1;
        chk_idle_outputs("midreset");
        repeat (3) @(negedge clk);
        clearn = 1'b1;
        expect_evt(12'h200, 49);
        wait_t(5 * FRAME);
        idle_frames(4);
        chk("t6_drain", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
